// File: rtl/ray_marcher.sv
// ray_marcher: per-pixel ray stepping controller driving the octree memory stage.
// Define RAY_MARCHER_STATS_EN to add o_ray_count / o_last_steps statistics outputs.
module ray_marcher #(
  parameter int POSITION_WIDTH = 16,
  parameter int DIR_WIDTH = 16,
  parameter int DIR_FRAC = 14,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 24,
  parameter int MAX_STEPS = 64,
  parameter logic [DATA_WIDTH-1:0] BACKGROUND = '0
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [POSITION_WIDTH-1:0]   i_origin [3],
  input  logic signed [DIR_WIDTH-1:0] i_direction [3],
  input  logic [ADDRESS_WIDTH-1:0]    i_ray_pixel_address,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_hit,
  output logic                        o_traverse,
  output logic [POSITION_WIDTH-1:0]   o_position [3],
  input  logic [3:0]                  i_depth,
  input  logic [DATA_WIDTH-1:0]       i_material,
  output logic                        o_write_pixel,
  output logic [DATA_WIDTH-1:0]       o_pixel,
  output logic [ADDRESS_WIDTH-1:0]    o_pixel_address,
  input  logic                        i_ready
`ifdef RAY_MARCHER_STATS_EN
  ,
  output logic [31:0]                 o_ray_count,
  output logic [7:0]                  o_last_steps
`endif
);
  localparam int CW = POSITION_WIDTH + DIR_WIDTH + 1;
  localparam int SW = $clog2(MAX_STEPS + 2);
  typedef enum logic [2:0] {IDLE, ISSUE, ACCEPT, RESULT, STEP, WRITE, WRITE_ACCEPT, WRITE_WAIT} state_t;
  state_t r_state, w_next;
  logic signed [DIR_WIDTH-1:0] r_dir [3];
  logic [POSITION_WIDTH-1:0] r_pos [3];
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_pixel;
  logic [SW-1:0] r_steps;
  logic r_hit, r_done;
  logic [31:0] w_shift;
  logic signed [CW-1:0] w_delta [3];
  logic signed [CW-1:0] w_next_pos [3];
  logic [2:0] w_out;
  logic w_zero_dir, w_miss, w_accept;
  assign o_busy = (r_state != IDLE) | r_done;
  assign o_done = r_done;
  assign o_hit = r_hit;
  assign o_position = r_pos;
  assign o_pixel = r_pixel;
  assign o_pixel_address = r_addr;
  assign w_accept = (r_state == IDLE) & i_start & ~r_done;
  // Leaf-sized step per axis; anything outside the unsigned cube shows up in the upper bits.
  always_comb begin
    w_shift = (32'(i_depth) >= 32'(POSITION_WIDTH)) ? 32'd0 : 32'(POSITION_WIDTH) - 32'(i_depth);
    for (int a = 0; a < 3; a++) begin
      w_delta[a] = (CW'(r_dir[a]) <<< w_shift) >>> DIR_FRAC;
      if (w_delta[a] == '0 && r_dir[a] != '0) w_delta[a] = r_dir[a][DIR_WIDTH-1] ? '1 : CW'(1);
      w_next_pos[a] = $signed(CW'(r_pos[a])) + w_delta[a];
      w_out[a] = |w_next_pos[a][CW-1:POSITION_WIDTH];
    end
    w_zero_dir = (r_dir[0] == '0) & (r_dir[1] == '0) & (r_dir[2] == '0);
    w_miss = (|w_out) | w_zero_dir | (r_steps == SW'(MAX_STEPS));
  end
  always_comb begin
    w_next = r_state;
    o_traverse = 1'b0;
    o_write_pixel = 1'b0;
    case (r_state)
      IDLE:         w_next = w_accept ? ISSUE : IDLE;
      ISSUE:        begin o_traverse = i_ready; w_next = i_ready ? ACCEPT : ISSUE; end
      ACCEPT:       w_next = RESULT;
      RESULT:       w_next = !i_ready ? RESULT : (i_material != '0) ? WRITE : STEP;
      STEP:         w_next = w_miss ? WRITE : ISSUE;
      WRITE:        begin o_write_pixel = i_ready; w_next = i_ready ? WRITE_ACCEPT : WRITE; end
      WRITE_ACCEPT: w_next = WRITE_WAIT;
      WRITE_WAIT:   w_next = i_ready ? IDLE : WRITE_WAIT;
      default:      w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_dir <= '{default: '0};
      r_pos <= '{default: '0};
      r_addr <= '0;
      r_pixel <= '0;
      r_steps <= '0;
      r_hit <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done <= (r_state == WRITE_WAIT) & i_ready;
      if (w_accept) begin
        r_pos <= i_origin;
        r_dir <= i_direction;
        r_addr <= i_ray_pixel_address;
        r_steps <= '0;
        r_hit <= 1'b0;
      end
      if (o_traverse) r_steps <= r_steps + SW'(1);
      if (r_state == RESULT && i_ready && i_material != '0) begin
        r_pixel <= i_material;
        r_hit <= 1'b1;
      end
      if (r_state == STEP) begin
        if (w_miss) begin
          r_pixel <= BACKGROUND;
          r_hit <= 1'b0;
        end else begin
          for (int a = 0; a < 3; a++) r_pos[a] <= w_next_pos[a][POSITION_WIDTH-1:0];
        end
      end
    end
  end
`ifdef RAY_MARCHER_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ray_count <= '0;
      o_last_steps <= '0;
    end else if (r_state == WRITE_WAIT && i_ready) begin
      o_ray_count <= o_ray_count + 32'd1;
      o_last_steps <= (32'(r_steps) > 32'd255) ? 8'hFF : 8'(r_steps);
    end
  end
`endif
endmodule

// File: tb/tb_ray_marcher.sv
// tb_ray_marcher: directed and random rays against a behavioural marching model,
// with the bench acting as the octree memory stage.
module tb_ray_marcher;
  logic clk = 1'b0;
  logic rst_n, start, ready;
  logic [15:0] origin [3];
  logic signed [15:0] direction [3];
  logic [31:0] ray_addr;
  logic busy, done, hit, traverse, write_pixel;
  logic [15:0] position [3];
  logic [3:0] depth;
  logic [23:0] material, pixel;
  logic [31:0] pixel_address;

  int total = 0, bad = 0;
  int trav_n, wr_n, done_n, viol, lat_min, lat_max, cfg_hk;
  logic [3:0] cfg_dep;
  logic [23:0] cfg_hm, wr_pix, exp_pix;
  logic [31:0] wr_addr;
  logic done_hit, exp_hit;
  logic [47:0] trav_q [$];
  logic [47:0] exp_q [$];

  ray_marcher dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_origin(origin),
    .i_direction(direction), .i_ray_pixel_address(ray_addr), .o_busy(busy),
    .o_done(done), .o_hit(hit), .o_traverse(traverse), .o_position(position),
    .i_depth(depth), .i_material(material), .o_write_pixel(write_pixel),
    .o_pixel(pixel), .o_pixel_address(pixel_address), .i_ready(ready)
  );

  always #5 clk = ~clk;

  // Memory stage: answers each request after a random number of busy cycles.
  initial begin
    ready = 1'b1;
    depth = '0;
    material = '0;
    forever begin
      @(negedge clk);
      if (traverse || write_pixel) begin
        if (traverse) begin
          trav_q.push_back({position[2], position[1], position[0]});
          trav_n++;
          depth = cfg_dep;
          material = (trav_n == cfg_hk) ? cfg_hm : 24'd0;
        end else begin
          wr_n++;
          wr_pix = pixel;
          wr_addr = pixel_address;
        end
        begin
          int lat;
          lat = $urandom_range(lat_max, lat_min);
          if (lat > 0) begin
            @(negedge clk);
            ready = 1'b0;
            repeat (lat) @(negedge clk);
            ready = 1'b1;
          end
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (done) begin done_n++; done_hit = hit; end
    if (((traverse || write_pixel) && !ready) || (traverse && write_pixel)) viol++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(input longint t, input longint d);
    return (t >= 0) ? t / d : -((-t + d - 1) / d);
  endfunction

  // Reference: list of positions visited and the pixel the ray ends with.
  function automatic void model(input logic [15:0] o [3], input logic signed [15:0] dv [3],
                                input int dep, input int hk, input logic [23:0] hm);
    longint p [3], np [3], dl;
    bit out;
    exp_q.delete();
    for (int a = 0; a < 3; a++) p[a] = longint'(o[a]);
    for (int k = 1; k <= 1000; k++) begin
      exp_q.push_back({p[2][15:0], p[1][15:0], p[0][15:0]});
      if (k == hk) begin exp_pix = hm; exp_hit = 1'b1; return; end
      out = (dv[0] == 0 && dv[1] == 0 && dv[2] == 0);
      for (int a = 0; a < 3; a++) begin
        dl = floor_div(longint'(dv[a]) * (64'sd1 <<< (16 - dep)), 16384);
        if (dl == 0 && dv[a] != 0) dl = (dv[a] > 0) ? 1 : -1;
        np[a] = p[a] + dl;
        if (np[a] < 0 || np[a] > 65535) out = 1;
      end
      if (out || k == 64) begin exp_pix = 24'h000000; exp_hit = 1'b0; return; end
      p = np;
    end
  endfunction

  task automatic run_ray(input logic [15:0] o0, o1, o2, input logic signed [15:0] d0, d1, d2,
                         input logic [3:0] dep, input int hk, input logic [23:0] hm,
                         input int lmin, input int lmax, input bit poke, input string tag);
    logic [15:0] o [3];
    logic signed [15:0] dv [3];
    logic [31:0] addr;
    int cyc;
    o = '{o0, o1, o2};
    dv = '{d0, d1, d2};
    model(o, dv, int'(dep), hk, hm);
    trav_q.delete();
    trav_n = 0; wr_n = 0; done_n = 0; viol = 0;
    cfg_dep = dep; cfg_hk = hk; cfg_hm = hm; lat_min = lmin; lat_max = lmax;
    addr = $urandom;
    @(negedge clk);
    origin = o; direction = dv; ray_addr = addr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    origin = '{16'h1111, 16'h2222, 16'h3333};
    ray_addr = ~addr;
    chk({tag, ":busy"}, 64'(busy), 64'd1);
    if (poke) begin
      repeat (3) @(negedge clk);
      origin = '{16'h0, 16'h0, 16'h0};
      direction = '{16'sd1, 16'sd0, 16'sd0};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (done_n == 0 && cyc < 5000) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    chk({tag, ":done"}, 64'(done_n), 64'd1);
    chk({tag, ":ntrav"}, 64'(trav_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < trav_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s:pos%0d", tag, i), 64'(trav_q[i]), 64'(exp_q[i]));
    chk({tag, ":nwrite"}, 64'(wr_n), 64'd1);
    chk({tag, ":pixel"}, 64'(wr_pix), 64'(exp_pix));
    chk({tag, ":addr"}, 64'(wr_addr), 64'(addr));
    chk({tag, ":hit"}, 64'(done_hit), 64'(exp_hit));
    chk({tag, ":proto"}, 64'(viol), 64'd0);
    chk({tag, ":idle"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ":busy"}, 64'(busy), 64'd0);
    chk({tag, ":done"}, 64'(done), 64'd0);
    chk({tag, ":hit"}, 64'(hit), 64'd0);
    chk({tag, ":trav"}, 64'(traverse), 64'd0);
    chk({tag, ":wp"}, 64'(write_pixel), 64'd0);
    chk({tag, ":pos"}, 64'({position[2], position[1], position[0]}), 64'd0);
    chk({tag, ":pixel"}, 64'(pixel), 64'd0);
    chk({tag, ":paddr"}, 64'(pixel_address), 64'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b1;
    start = 1'b0;
    origin = '{16'h0, 16'h0, 16'h0};
    direction = '{16'sd0, 16'sd0, 16'sd0};
    ray_addr = '0;
    lat_min = 0; lat_max = 0; cfg_hk = 0; cfg_dep = '0; cfg_hm = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    run_ray(16'h8000, 16'h8000, 16'h8000, 16'sd16384, 16'sd0, 16'sd0, 4'd1, 0, 24'h0, 0, 2, 0, "exit");
    run_ray(16'h8000, 16'h8000, 16'h8000, 16'sd16384, 16'sd0, 16'sd0, 4'd1, 1, 24'h5, 0, 2, 0, "hit1");
    run_ray(16'h0, 16'h0, 16'h0, 16'sd16384, 16'sd8192, 16'sd0, 4'd4, 2, 24'h7, 1, 3, 0, "hit2");
    run_ray(16'h0, 16'h0, 16'h0, 16'sd1, 16'sd0, 16'sd0, 4'd15, 0, 24'h0, 0, 1, 0, "limit");
    run_ray(16'd100, 16'd200, 16'd300, 16'sd0, 16'sd0, -16'sd16384, 4'd8, 0, 24'h0, 10, 10, 1, "busy");
    run_ray(16'h1234, 16'h5678, 16'h9abc, 16'sd0, 16'sd0, 16'sd0, 4'd3, 0, 24'h0, 0, 2, 0, "zero");
    run_ray(16'h0003, 16'hfffe, 16'h4000, -16'sd1, 16'sd1, 16'sd0, 4'd15, 0, 24'h0, 0, 1, 0, "edge");
    for (int r = 0; r < 10; r++)
      run_ray(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 4'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
              24'($urandom_range(1, 24'hffffff)), 0, 3, 0, $sformatf("rnd%0d", r));
    // Abandon a ray while it waits for a slow traversal result.
    trav_q.delete();
    trav_n = 0; cfg_dep = 4'd2; cfg_hk = 0; lat_min = 20; lat_max = 20;
    @(negedge clk);
    origin = '{16'd10, 16'd10, 16'd10};
    direction = '{16'sd16384, 16'sd0, 16'sd0};
    ray_addr = 32'hdead_beef;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (trav_n == 0 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("rst:trav", 64'(trav_n), 64'd1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (!ready && cyc < 200) begin @(negedge clk); cyc++; end
    run_ray(16'h0, 16'h0, 16'h0, 16'sd16384, 16'sd8192, 16'sd0, 4'd4, 2, 24'h7, 0, 2, 0, "after");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
